// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared constants and hex-to-segment table for the 7-segment scan driver
package seg7_pkg;

  localparam int NUM_DIGITS = 4;
  localparam logic [6:0] SEG_OFF = 7'h7F;

  // Active-low {g,f,e,d,c,b,a}
  function automatic logic [6:0] seg7_hex_to_seg(input logic [3:0] nibble);
    logic [6:0] seg;
    seg = SEG_OFF;
    case (nibble)
      4'h0: seg = 7'b1000000;
      4'h1: seg = 7'b1111001;
      4'h2: seg = 7'b0100100;
      4'h3: seg = 7'b0110000;
      4'h4: seg = 7'b0011001;
      4'h5: seg = 7'b0010010;
      4'h6: seg = 7'b0000010;
      4'h7: seg = 7'b1111000;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0010000;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b0000011;
      4'hC: seg = 7'b1000110;
      4'hD: seg = 7'b0100001;
      4'hE: seg = 7'b0000110;
      4'hF: seg = 7'b0001110;
      default: seg = SEG_OFF;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/seg7_hex_decoder.sv
// rtl/seg7_hex_decoder.sv - combinational nibble to active-low segment decoder
module seg7_hex_decoder
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = seg7_hex_to_seg(nibble);

endmodule

// File: rtl/seg7_scan_driver.sv
// rtl/seg7_scan_driver.sv - time-multiplexed 4-digit common-anode display driver
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int DIGIT_CYCLES = 100_000,
  parameter int BLANK_CYCLES = 1_000
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [NUM_DIGITS-1:0][3:0] dig,
  input  logic [NUM_DIGITS-1:0]      blank_mask,
  input  logic [NUM_DIGITS-1:0]      dp_mask,
  input  logic                       lzs_en,
  output logic [6:0]                 seg,
  output logic                       dp_n,
  output logic [NUM_DIGITS-1:0]      an,
  output logic                       frame_start
);

  localparam int CW = $clog2(DIGIT_CYCLES);
  localparam logic [CW-1:0] CNT_LAST  = CW'(DIGIT_CYCLES - 1);
  localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYCLES);

  if (BLANK_CYCLES >= DIGIT_CYCLES) begin : g_bad_blank
    $error("seg7_scan_driver: BLANK_CYCLES must be less than DIGIT_CYCLES");
  end

  logic [CW-1:0]                cnt;
  logic [1:0]                   idx;
  logic [NUM_DIGITS-1:0][3:0]   dig_sh;
  logic [NUM_DIGITS-1:0]        blank_sh;
  logic [NUM_DIGITS-1:0]        dp_sh;
  logic                         lzs_sh;

  logic                         snap;
  logic [NUM_DIGITS-1:0][3:0]   dig_eff;
  logic [NUM_DIGITS-1:0]        blank_eff;
  logic [NUM_DIGITS-1:0]        dp_eff;
  logic                         lzs_eff;
  logic [6:0]                   dec_seg;
  logic                         lead_zero;
  logic [NUM_DIGITS-1:0]        an_d;
  logic [6:0]                   seg_d;
  logic                         dp_d;

  assign snap = (idx == 2'd0) && (cnt == '0);

  // During the snapshot cycle the shadow regs are not yet loaded, so bypass them
  always_comb begin
    dig_eff   = snap ? dig        : dig_sh;
    blank_eff = snap ? blank_mask : blank_sh;
    dp_eff    = snap ? dp_mask    : dp_sh;
    lzs_eff   = snap ? lzs_en     : lzs_sh;
  end

  seg7_hex_decoder u_dec (
    .nibble (dig_eff[idx]),
    .seg    (dec_seg)
  );

  always_comb begin
    an_d      = '1;
    seg_d     = SEG_OFF;
    dp_d      = 1'b1;
    lead_zero = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (i >= int'(idx) && dig_eff[i] != 4'h0) lead_zero = 1'b0;
    end
    if (cnt >= BLANK_END && !blank_eff[idx] &&
        !(lzs_eff && idx != 2'd0 && lead_zero)) begin
      an_d  = ~(NUM_DIGITS'(1) << idx);
      seg_d = dec_seg;
      dp_d  = ~dp_eff[idx];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt         <= '0;
      idx         <= 2'd0;
      dig_sh      <= '0;
      blank_sh    <= '0;
      dp_sh       <= '0;
      lzs_sh      <= 1'b0;
      an          <= '1;
      seg         <= SEG_OFF;
      dp_n        <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      if (cnt == CNT_LAST) begin
        cnt <= '0;
        idx <= idx + 2'd1;
      end else begin
        cnt <= cnt + CW'(1);
      end
      if (snap) begin
        dig_sh   <= dig;
        blank_sh <= blank_mask;
        dp_sh    <= dp_mask;
        lzs_sh   <= lzs_en;
      end
      an          <= an_d;
      seg         <= seg_d;
      dp_n        <= dp_d;
      frame_start <= snap;
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb/tb_seg7_scan_driver.sv - randomized self-checking bench against a frame-level display model
module tb_seg7_scan_driver;

  localparam int DC = 8;
  localparam int BC = 2;
  localparam int FRAME = 4 * DC;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic [3:0][3:0]  dig = '0;
  logic [3:0]       blank_mask = '0;
  logic [3:0]       dp_mask = '0;
  logic             lzs_en = 1'b0;
  logic [6:0]       seg;
  logic             dp_n;
  logic [3:0]       an;
  logic             frame_start;

  int total = 0;
  int bad = 0;

  // cycles since reset release; the next released edge takes a snapshot when k%FRAME==0
  int k = 0;
  logic [15:0] m_val = '0;
  logic [3:0]  m_blank = '0;
  logic [3:0]  m_dp = '0;
  logic        m_lzs = 1'b0;

  logic [6:0] hex_tab [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  seg7_scan_driver #(
    .DIGIT_CYCLES (DC),
    .BLANK_CYCLES (BC)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .dig         (dig),
    .blank_mask  (blank_mask),
    .dp_mask     (dp_mask),
    .lzs_en      (lzs_en),
    .seg         (seg),
    .dp_n        (dp_n),
    .an          (an),
    .frame_start (frame_start)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s k=%0d got=%h exp=%h", tag, k, got, exp);
    end
  endtask

  task automatic cycle();
    logic [3:0] e_an;
    logic [6:0] e_seg;
    logic       e_dp;
    logic       e_fs;
    int         slot;
    int         c;
    e_an  = 4'hF;
    e_seg = 7'h7F;
    e_dp  = 1'b1;
    e_fs  = 1'b0;
    @(posedge clk);
    #1;
    if (!reset_n) begin
      k = 0;
    end else begin
      if (k % FRAME == 0) begin
        m_val   = dig;
        m_blank = blank_mask;
        m_dp    = dp_mask;
        m_lzs   = lzs_en;
        e_fs    = 1'b1;
      end
      slot = (k / DC) % 4;
      c    = k % DC;
      if (c >= BC && !m_blank[slot] &&
          !(m_lzs && slot > 0 && (m_val >> (4 * slot)) == 16'd0)) begin
        e_an  = ~(4'b0001 << slot);
        e_seg = hex_tab[(m_val >> (4 * slot)) & 16'hF];
        e_dp  = ~m_dp[slot];
      end
      k++;
    end
    check("an", 32'(an), 32'(e_an));
    check("seg", 32'(seg), 32'(e_seg));
    check("dp_n", 32'(dp_n), 32'(e_dp));
    check("frame_start", 32'(frame_start), 32'(e_fs));
    check("an_onehot", 32'($countones(~an) <= 1), 32'd1);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic run_to(input int phase);
    for (int n = 0; n < 2 * FRAME && (k % FRAME) != phase; n++) cycle();
  endtask

  initial begin
    dig = 16'hA5C3;
    blank_mask = 4'b0101;
    lzs_en = 1'b1;
    reset_n = 1'b0;
    run(5);

    reset_n = 1'b1;
    dig = 16'h1234;
    blank_mask = '0;
    dp_mask = '0;
    lzs_en = 1'b0;
    run(2 * FRAME);

    run_to(2 * DC + BC + 1);
    dig = 16'hFFFF;
    run(FRAME + 8);

    lzs_en = 1'b1;
    dig = 16'h0005;
    run(2 * FRAME);
    dig = 16'h0000;
    run(2 * FRAME);
    dig = 16'h0300;
    run(2 * FRAME);

    lzs_en = 1'b0;
    blank_mask = 4'b0010;
    dp_mask = 4'b0011;
    dig = 16'h8888;
    run(2 * FRAME);

    run_to(2 * DC + BC + 2);
    reset_n = 1'b0;
    cycle();
    reset_n = 1'b1;
    run(FRAME + 4);

    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        dig = 16'($urandom);
        if ($urandom_range(0, 1) == 0) dig[3:2] = '0;
        blank_mask = 4'($urandom_range(0, 15) & $urandom_range(0, 15));
        dp_mask = 4'($urandom_range(0, 15));
        lzs_en = 1'($urandom_range(0, 1));
      end
      reset_n = ($urandom_range(0, 99) != 0);
      cycle();
    end
    reset_n = 1'b1;
    run(FRAME);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
